// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver with its receive FIFO.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // Bit-period divisors (period minus one) for a 25 MHz system clock
  localparam int DIV_115200 = 216;
  localparam int DIV_19200  = 1301;

  // FIFO entry layout: {perr, ferr, data[7:0]}
  localparam int ENTRY_W = 10;

  // Reserved mode 11 behaves like no parity
  function automatic logic par_enabled(input logic [1:0] pm);
    return (pm == PAR_EVEN) || (pm == PAR_ODD);
  endfunction

  // 7-bit frames arrive left-aligned in the shifter; move them down so bit 7 reads 0
  function automatic logic [7:0] justify(input logic [7:0] sh, input logic b7);
    return b7 ? {1'b0, sh[7:1]} : sh;
  endfunction

endpackage

// File: rtl/rx_fifo.sv
// Small synchronous FIFO holding received characters; head is shown while not empty.
module rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_pop;
  logic             do_push;

  // A push into a full FIFO only lands if a pop frees a slot on the same cycle
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign head  = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally as DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver: synchronizes RxD, frames characters with optional parity and
// queues {perr, ferr, data} entries in a receive FIFO with a sticky overrun flag.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             RxD,
  input  logic [DIV_W-1:0] div,
  input  logic             bits7,
  input  logic [1:0]       par_mode,
  input  logic             done,
  output logic             rdy,
  output logic [7:0]       data,
  output logic             perr,
  output logic             ferr,
  output logic             ovr,
  input  logic             ovr_clr
);

  rx_state_t          state;
  logic               s0;
  logic               s1;
  logic               s_prev;
  logic [DIV_W-1:0]   tick;
  logic [DIV_W-1:0]   div_r;
  logic               b7_r;
  logic [1:0]         pm_r;
  logic [3:0]         bit_cnt;
  logic [7:0]         shreg;
  logic               perr_r;
  logic               mid;
  logic               bit_end;
  logic               fall;
  logic [3:0]         n_bits;
  logic               push;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] entry;
  logic [ENTRY_W-1:0] head;

  assign mid     = (tick == (div_r >> 1));
  assign bit_end = (tick == div_r);
  assign fall    = s_prev & ~s1;
  assign n_bits  = b7_r ? 4'd7 : 4'd8;

  // Stop bit is sampled at its mid; the entry is written on that same cycle
  assign push  = enable & (state == STOP) & mid;
  assign pop   = enable & done;
  assign entry = {perr_r, ~s1, justify(shreg, b7_r)};

  // Two-flop synchronizer plus one history flop for falling-edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0     <= 1'b1;
      s1     <= 1'b1;
      s_prev <= 1'b1;
    end else if (enable) begin
      s0     <= RxD;
      s1     <= s0;
      s_prev <= s1;
    end
  end

  // Frame sequencer: bit-period timing, state progression and per-frame settings
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      tick    <= '0;
      div_r   <= '0;
      b7_r    <= 1'b0;
      pm_r    <= PAR_NONE;
      bit_cnt <= '0;
    end else if (enable) begin
      if (state == IDLE || bit_end) tick <= '0;
      else                          tick <= tick + 1'b1;
      case (state)
        IDLE: begin
          if (fall) begin
            state <= START;
            div_r <= div;
            b7_r  <= bits7;
            pm_r  <= par_mode;
          end
        end
        START: begin
          if (mid && s1) begin
            state <= IDLE;
            tick  <= '0;
          end else if (bit_end) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (mid) bit_cnt <= bit_cnt + 1'b1;
          if (bit_end && bit_cnt == n_bits)
            state <= par_enabled(pm_r) ? PARITY : STOP;
        end
        PARITY: begin
          if (bit_end) state <= STOP;
        end
        STOP: begin
          if (mid) begin
            state <= IDLE;
            tick  <= '0;
          end
        end
        default: begin
          state <= IDLE;
          tick  <= '0;
        end
      endcase
    end
  end

  // Data capture: LSB-first shift at each data-bit mid, parity check at the parity mid
  always_ff @(posedge clk) begin
    if (enable) begin
      if (state == IDLE) begin
        shreg  <= '0;
        perr_r <= 1'b0;
      end
      if (state == DATA && mid)
        shreg <= {s1, shreg[7:1]};
      if (state == PARITY && mid)
        perr_r <= ((^shreg) ^ s1) != (pm_r == PAR_ODD);
    end
  end

  // Sticky overrun: a dropped entry sets it, and setting beats a concurrent clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovr <= 1'b0;
    end else if (enable) begin
      if (push && fifo_full && !pop) ovr <= 1'b1;
      else if (ovr_clr)              ovr <= 1'b0;
    end
  end

  rx_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (push),
    .wdata (entry),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head)
  );

  assign rdy               = ~fifo_empty;
  assign {perr, ferr, data} = head;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: frames are driven on RxD, expected FIFO entries are
// queued from the framing rules, and a monitor compares every popped head entry.
module tb_uart_rx_fifo;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b1;
  logic        RxD = 1'b1;
  logic [15:0] div = 16'd216;
  logic        bits7 = 1'b0;
  logic [1:0]  par_mode = 2'b00;
  logic        done = 1'b0;
  logic        ovr_clr = 1'b0;
  logic        rdy;
  logic [7:0]  data;
  logic        perr;
  logic        ferr;
  logic        ovr;

  uart_rx_fifo #(
    .DIV_W      (16),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .RxD      (RxD),
    .div      (div),
    .bits7    (bits7),
    .par_mode (par_mode),
    .done     (done),
    .rdy      (rdy),
    .data     (data),
    .perr     (perr),
    .ferr     (ferr),
    .ovr      (ovr),
    .ovr_clr  (ovr_clr)
  );

  always #5 clk = ~clk;

  int         cyc = 0;
  int         n_vec = 0;
  int         n_miss = 0;
  logic [9:0] exp_q[$];
  logic       exp_ovr = 1'b0;
  logic       auto_pop = 1'b1;
  int         pop_at = -1;
  int         start_cyc = 0;
  int         lat = 0;
  int         rise_cyc = -1;
  logic       rdy_q = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reader: pops whenever allowed, or exactly on a scheduled cycle
  initial begin
    forever begin
      @(posedge clk);
      #1;
      done = (rdy === 1'b1) && (auto_pop || cyc == pop_at);
    end
  end

  // Monitor: every pop is compared against the oldest expected entry
  always @(negedge clk) begin
    if (rst && done && rdy) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_entry: got %0h, expected none", {perr, ferr, data});
      end else begin
        check("entry", int'({perr, ferr, data}), int'(exp_q.pop_front()));
      end
    end
    if (rdy && !rdy_q) rise_cyc <= cyc;
    rdy_q <= rdy;
  end

  // Drive one frame; the expected entry (or an expected overrun) is recorded up front
  task automatic send_frame(input logic [7:0] d, input logic b7, input logic [1:0] pm,
                            input logic pbit, input logic sbit, input logic sim_pop);
    logic [7:0] dd;
    logic [9:0] e;
    int nd;
    int np;
    int ones;
    dd   = b7 ? {1'b0, d[6:0]} : d;
    nd   = b7 ? 7 : 8;
    np   = (pm == 2'b01 || pm == 2'b10) ? 1 : 0;
    ones = $countones(dd) + int'(pbit);
    e[7:0] = dd;
    e[8]   = ~sbit;
    e[9]   = (np == 1) ? (((ones % 2) == 1) != (pm == 2'b10)) : 1'b0;
    if (exp_q.size() >= DEPTH && !sim_pop) exp_ovr = 1'b1;
    else exp_q.push_back(e);
    bits7    = b7;
    par_mode = pm;
    lat = 4 + (nd + np + 1) * (int'(div) + 1) + int'(div) / 2;
    RxD = 1'b0;
    start_cyc = cyc;
    if (sim_pop) pop_at = start_cyc + lat - 1;
    tick_n(int'(div) + 1);
    for (int i = 0; i < nd; i++) begin
      RxD = dd[i];
      tick_n(int'(div) + 1);
    end
    if (np == 1) begin
      RxD = pbit;
      tick_n(int'(div) + 1);
    end
    RxD = sbit;
    tick_n(int'(div) + 1);
    RxD = 1'b1;
    tick_n(4);
  endtask

  task automatic drain();
    auto_pop = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick_n(1);
    check("drain_queue_empty", exp_q.size(), 0);
    tick_n(2);
    check("drain_rdy_low", int'(rdy), 0);
  endtask

  initial begin
    int s;
    int l;
    logic [7:0] rd;
    tick_n(3);
    check("reset_rdy", int'(rdy), 0);
    check("reset_data", int'(data), 0);
    check("reset_perr", int'(perr), 0);
    check("reset_ferr", int'(ferr), 0);
    check("reset_ovr", int'(ovr), 0);
    rst = 1'b1;
    tick_n(5);

    // 8N1 at 115200: exact rdy latency, then pop
    div = 16'd216;
    auto_pop = 1'b0;
    send_frame(8'hA5, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    check("rdy_latency", rise_cyc, start_cyc + lat);
    check("rdy_held_without_done", int'(rdy), 1);
    drain();

    // Glitch shorter than half a bit is a false start
    RxD = 1'b0;
    tick_n(50);
    RxD = 1'b1;
    tick_n(400);
    check("false_start_rdy", int'(rdy), 0);

    // Parity and framing cases at a short bit period
    div = 16'd31;
    send_frame(8'h3C, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    send_frame(8'h03, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0);
    send_frame(8'h03, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0);
    send_frame(8'h7F, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    send_frame(8'hC6, 1'b0, 2'b11, 1'b1, 1'b1, 1'b0);
    drain();

    // Overrun: five frames into four slots
    auto_pop = 1'b0;
    exp_ovr = 1'b0;
    for (int k = 1; k <= 5; k++) send_frame(8'(k), 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    check("ovr_after_overflow", int'(ovr), int'(exp_ovr));
    check("rdy_when_full", int'(rdy), 1);
    drain();
    ovr_clr = 1'b1;
    tick_n(1);
    ovr_clr = 1'b0;
    exp_ovr = 1'b0;
    check("ovr_cleared", int'(ovr), int'(exp_ovr));

    // Full FIFO with a pop on the write cycle: both happen, no overrun
    auto_pop = 1'b0;
    for (int k = 8'h11; k <= 8'h14; k++) send_frame(8'(k), 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    send_frame(8'h15, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
    pop_at = -1;
    check("ovr_push_pop_full", int'(ovr), int'(exp_ovr));
    drain();

    // Overrun set coinciding with ovr_clr: set wins
    auto_pop = 1'b0;
    for (int k = 8'h21; k <= 8'h24; k++) send_frame(8'(k), 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    s = cyc;
    l = 4 + 9 * (int'(div) + 1) + int'(div) / 2;
    fork
      send_frame(8'h25, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
      begin
        tick_n(l - 1);
        ovr_clr = 1'b1;
        tick_n(1);
        check("ovr_set_beats_clr", int'(ovr), 1);
        ovr_clr = 1'b0;
      end
    join
    check("ovr_still_set", int'(ovr), int'(exp_ovr));
    drain();
    ovr_clr = 1'b1;
    tick_n(1);
    ovr_clr = 1'b0;
    exp_ovr = 1'b0;
    check("ovr_cleared_again", int'(ovr), 0);

    // Reset in the middle of data bit 3 of 0x5A
    div = 16'd216;
    bits7 = 1'b0;
    par_mode = 2'b00;
    rd = 8'h5A;
    RxD = 1'b0;
    tick_n(217);
    for (int i = 0; i < 3; i++) begin
      RxD = rd[i];
      tick_n(217);
    end
    RxD = rd[3];
    tick_n(100);
    rst = 1'b0;
    RxD = 1'b1;
    tick_n(2);
    check("midreset_rdy", int'(rdy), 0);
    check("midreset_data", int'(data), 0);
    check("midreset_ovr", int'(ovr), 0);
    tick_n(3);
    rst = 1'b1;
    tick_n(20);
    check("after_reset_rdy", int'(rdy), 0);
    send_frame(8'h5A, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    drain();

    // Randomized frames at varied bit periods and formats
    for (int n = 0; n < 30; n++) begin
      div = 16'($urandom_range(15, 40));
      send_frame(8'($urandom), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), 1'b0);
      tick_n($urandom_range(0, 6));
    end
    drain();
    check("final_ovr", int'(ovr), int'(exp_ovr));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "simulation timeout");
  end

endmodule
